// File: rtl/music_box_pkg.sv
// Shared definitions for the music box user-interface sequencer and the
// state modules that watch its currentState output.
package music_box_pkg;

    // State codes broadcast on currentState; state modules compare against these.
    typedef enum logic [4:0] {
        DO_NOTHING     = 5'd0,
        PLAY_SONG0     = 5'd1,
        PLAY_SONG1     = 5'd2,
        RECORD_AUDIO   = 5'd3,
        PLAY_RECORDING = 5'd4
    } state_code_t;

    // Why the most recent active state ended.
    typedef enum logic [1:0] {
        EXIT_NONE     = 2'd0,
        EXIT_COMPLETE = 2'd1,
        EXIT_STOP     = 2'd2,
        EXIT_TIMEOUT  = 2'd3
    } exit_reason_t;

    // Request-bit positions on requestPulse.
    localparam int unsigned NUM_REQUESTS           = 4;
    localparam int unsigned REQ_BIT_PLAY_SONG0     = 0;
    localparam int unsigned REQ_BIT_PLAY_SONG1     = 1;
    localparam int unsigned REQ_BIT_RECORD_AUDIO   = 2;
    localparam int unsigned REQ_BIT_PLAY_RECORDING = 3;

    // Lowest-index request wins when several bits are set together.
    function automatic state_code_t request_to_state(input logic [NUM_REQUESTS-1:0] req);
        if (req[REQ_BIT_PLAY_SONG0])     return PLAY_SONG0;
        if (req[REQ_BIT_PLAY_SONG1])     return PLAY_SONG1;
        if (req[REQ_BIT_RECORD_AUDIO])   return RECORD_AUDIO;
        if (req[REQ_BIT_PLAY_RECORDING]) return PLAY_RECORDING;
        return DO_NOTHING;
    endfunction

endpackage

// File: rtl/music_box_state_controller_watchdog.sv
// Active-state watchdog: counts enabled cycles since the last clear and
// flags the cycle that completes TIMEOUT_CYCLES enabled cycles.
// Only instantiated when MUSICBOX_TIMEOUT_EN is defined.
module music_box_watchdog #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [31:0] count;

    // Cycle counter, restarted on every entry into an active state.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 32'd1;
        end
    end

    assign expired = enable && (count == TIMEOUT_CYCLES - 32'd1);

endmodule

// File: rtl/music_box_state_controller.sv
// Music box UI sequencer: turns one-cycle request pulses into a registered
// currentState code, returns to DoNothing on completion/stop, and holds off
// new requests for a guard interval after every exit.
// Optional watchdog (exit reason 3) is compiled in with MUSICBOX_TIMEOUT_EN.
module music_box_state_controller
    import music_box_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES   = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
    input  logic        clock_50Mhz,
    input  logic        reset,
    input  logic [3:0]  requestPulse,
    input  logic        stopPulse,
    input  logic [4:0]  stateComplete,
    output logic [4:0]  currentState,
    output logic        busy,
    output logic [31:0] debugString
);

    localparam int unsigned GUARD_W = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_GUARD,
        CTRL_ACTIVE
    } ctrl_state_t;

    ctrl_state_t        ctrl_state;
    state_code_t        current_state;
    exit_reason_t       exit_reason;
    exit_reason_t       exit_next;
    logic [GUARD_W-1:0] guard_cnt;
    logic [7:0]         drop_count;
    logic [15:0]        entry_count;
    logic               busy_q;

    logic request_any;
    logic accept;
    logic complete_hit;
    logic timeout_hit;
    logic exit_valid;

    logic unused_complete_bit;
    assign unused_complete_bit = stateComplete[0];

`ifdef MUSICBOX_TIMEOUT_EN
    logic wd_expired;

    music_box_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clock_50Mhz),
        .reset   (reset),
        .clear   (accept),
        .enable  (ctrl_state == CTRL_ACTIVE),
        .expired (wd_expired)
    );

    assign timeout_hit = wd_expired;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    // Request detection and exit priority: stop > complete > timeout.
    always_comb begin
        request_any  = (requestPulse != '0);
        accept       = (ctrl_state == CTRL_IDLE) && request_any;
        complete_hit = 1'b0;
        unique case (current_state)
            PLAY_SONG0:     complete_hit = stateComplete[1];
            PLAY_SONG1:     complete_hit = stateComplete[2];
            RECORD_AUDIO:   complete_hit = stateComplete[3];
            PLAY_RECORDING: complete_hit = stateComplete[4];
            default:        complete_hit = 1'b0;
        endcase
        exit_valid = 1'b0;
        exit_next  = EXIT_NONE;
        if (ctrl_state == CTRL_ACTIVE) begin
            if (stopPulse) begin
                exit_valid = 1'b1;
                exit_next  = EXIT_STOP;
            end else if (complete_hit) begin
                exit_valid = 1'b1;
                exit_next  = EXIT_COMPLETE;
            end else if (timeout_hit) begin
                exit_valid = 1'b1;
                exit_next  = EXIT_TIMEOUT;
            end
        end
    end

    // Sequencer FSM with all outputs and debug counters registered.
    // GUARD leaves one cycle early (at count 1) so the count reads 0 exactly
    // in the first cycle that a request can be accepted again.
    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            ctrl_state    <= CTRL_IDLE;
            current_state <= DO_NOTHING;
            exit_reason   <= EXIT_NONE;
            guard_cnt     <= '0;
            drop_count    <= '0;
            entry_count   <= '0;
            busy_q        <= 1'b0;
        end else begin
            unique case (ctrl_state)
                CTRL_IDLE: begin
                    if (accept) begin
                        ctrl_state    <= CTRL_ACTIVE;
                        current_state <= request_to_state(requestPulse);
                        entry_count   <= entry_count + 16'd1;
                        busy_q        <= 1'b1;
                    end
                end
                CTRL_ACTIVE: begin
                    if (request_any && (drop_count != '1)) begin
                        drop_count <= drop_count + 8'd1;
                    end
                    if (exit_valid) begin
                        ctrl_state    <= CTRL_GUARD;
                        current_state <= DO_NOTHING;
                        exit_reason   <= exit_next;
                        guard_cnt     <= GUARD_W'(GUARD_CYCLES);
                    end
                end
                CTRL_GUARD: begin
                    if (request_any && (drop_count != '1)) begin
                        drop_count <= drop_count + 8'd1;
                    end
                    guard_cnt <= guard_cnt - GUARD_W'(1);
                    if (guard_cnt == GUARD_W'(1)) begin
                        ctrl_state <= CTRL_IDLE;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    ctrl_state <= CTRL_IDLE;
                end
            endcase
        end
    end

    assign currentState = current_state;
    assign busy         = busy_q;
    assign debugString  = {entry_count, drop_count, 1'b0, exit_reason, current_state};

endmodule

// File: tb/tb_music_box_state_controller.sv
// Self-checking bench for music_box_state_controller. A cycle model predicts
// the outputs for every driven cycle; predictions are queued and compared one
// cycle later. Honours MUSICBOX_TIMEOUT_EN for the watchdog expectations.
module tb_music_box_state_controller;

    localparam int unsigned GUARD   = 4;
    localparam int unsigned TIMEOUT = 16;

    logic        clock_50Mhz = 1'b0;
    logic        reset;
    logic [3:0]  requestPulse;
    logic        stopPulse;
    logic [4:0]  stateComplete;
    logic [4:0]  currentState;
    logic        busy;
    logic [31:0] debugString;

    typedef struct packed {
        logic [4:0]  state;
        logic        busy;
        logic [31:0] debug;
    } expect_t;

    expect_t     sb_queue[$];
    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    int m_state;
    int m_guard;
    int m_reason;
    int m_drop;
    int m_entry;
    int m_wd;

    music_box_state_controller #(
        .GUARD_CYCLES   (GUARD),
        .TIMEOUT_CYCLES (32'(TIMEOUT))
    ) dut (
        .clock_50Mhz   (clock_50Mhz),
        .reset         (reset),
        .requestPulse  (requestPulse),
        .stopPulse     (stopPulse),
        .stateComplete (stateComplete),
        .currentState  (currentState),
        .busy          (busy),
        .debugString   (debugString)
    );

    always #10 clock_50Mhz = ~clock_50Mhz;

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Behavioural reference: what the outputs must be after this cycle's edge.
    function automatic void model_step(input logic rst, input logic [3:0] req,
                                       input logic stop, input logic [4:0] comp);
        int  reason;
        if (rst) begin
            m_state = 0; m_guard = 0; m_reason = 0; m_drop = 0; m_entry = 0; m_wd = 0;
            return;
        end
        if (m_state != 0) begin
            if (req != 4'd0 && m_drop < 255) m_drop++;
            reason = 0;
            if (stop)                reason = 2;
            else if (comp[m_state])  reason = 1;
`ifdef MUSICBOX_TIMEOUT_EN
            else if (m_wd == TIMEOUT - 1) reason = 3;
`endif
            if (reason != 0) begin
                m_state  = 0;
                m_reason = reason;
                m_guard  = GUARD;
            end else begin
                m_wd++;
            end
        end else if (m_guard > 0) begin
            if (req != 4'd0 && m_drop < 255) m_drop++;
            m_guard--;
        end else if (req != 4'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    m_state = i + 1;
                    break;
                end
            end
            m_entry = (m_entry + 1) % 65536;
            m_wd    = 0;
        end
    endfunction

    task automatic drive_cycle(input logic rst, input logic [3:0] req,
                               input logic stop, input logic [4:0] comp);
        expect_t e;
        reset         = rst;
        requestPulse  = req;
        stopPulse     = stop;
        stateComplete = comp;
        model_step(rst, req, stop, comp);
        e.state = m_state[4:0];
        e.busy  = (m_state != 0) || (m_guard != 0);
        e.debug = {m_entry[15:0], m_drop[7:0], 1'b0, m_reason[1:0], m_state[4:0]};
        sb_queue.push_back(e);
        @(posedge clock_50Mhz);
        #1;
        e = sb_queue.pop_front();
        check_value("currentState", 32'(currentState), 32'(e.state));
        check_value("busy", 32'(busy), 32'(e.busy));
        check_value("debugString", debugString, e.debug);
        reset         = 1'b0;
        requestPulse  = 4'd0;
        stopPulse     = 1'b0;
        stateComplete = 5'd0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) drive_cycle(1'b0, 4'd0, 1'b0, 5'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        reset = 1'b1; requestPulse = 4'd0; stopPulse = 1'b0; stateComplete = 5'd0;
        m_state = 0; m_guard = 0; m_reason = 0; m_drop = 0; m_entry = 0; m_wd = 0;

        // Reset state
        drive_cycle(1'b1, 4'd0, 1'b0, 5'd0);
        drive_cycle(1'b1, 4'd0, 1'b0, 5'd0);
        check_value("reset_debug", debugString, 32'd0);

        // Single request, completion, guard interval
        drive_cycle(1'b0, 4'b0001, 1'b0, 5'd0);
        check_value("req0_state", 32'(currentState), 32'd1);
        idle(2);
        drive_cycle(1'b0, 4'd0, 1'b0, 5'b00010);
        check_value("complete_reason", 32'(debugString[6:5]), 32'd1);
        check_value("complete_busy", 32'(busy), 32'd1);
        idle(GUARD + 1);

        // Simultaneous requests: lowest index wins
        drive_cycle(1'b0, 4'b1010, 1'b0, 5'd0);
        check_value("simul_state", 32'(currentState), 32'd2);
        check_value("simul_entries", 32'(debugString[31:16]), 32'd2);
        drive_cycle(1'b0, 4'd0, 1'b1, 5'd0);
        idle(GUARD);

        // Wrong completion bit ignored; stop beats completion
        drive_cycle(1'b0, 4'b0100, 1'b0, 5'd0);
        drive_cycle(1'b0, 4'd0, 1'b0, 5'b00010);
        check_value("wrong_bit_state", 32'(currentState), 32'd3);
        drive_cycle(1'b0, 4'd0, 1'b1, 5'b01000);
        check_value("stop_reason", 32'(debugString[6:5]), 32'd2);
        // Request one cycle early is dropped, at the boundary it is accepted
        idle(GUARD - 1);
        drive_cycle(1'b0, 4'b0001, 1'b0, 5'd0);
        check_value("guard_edge_drop", 32'(currentState), 32'd0);
        drive_cycle(1'b0, 4'b0001, 1'b0, 5'd0);
        check_value("guard_edge_accept", 32'(currentState), 32'd1);
        drive_cycle(1'b0, 4'd0, 1'b0, 5'b00010);
        idle(GUARD);

        // Dropped requests during ACTIVE and GUARD, then saturation
        drive_cycle(1'b1, 4'd0, 1'b0, 5'd0);
        drive_cycle(1'b0, 4'b0001, 1'b0, 5'd0);
        drive_cycle(1'b0, 4'b0010, 1'b0, 5'd0);
        drive_cycle(1'b0, 4'b0100, 1'b0, 5'd0);
        drive_cycle(1'b0, 4'd0, 1'b0, 5'b00010);
        drive_cycle(1'b0, 4'b1000, 1'b0, 5'd0);
        check_value("drop_count3", 32'(debugString[15:8]), 32'd3);
        idle(GUARD);
        drive_cycle(1'b0, 4'b0001, 1'b0, 5'd0);
        for (int i = 0; i < 300; i++) drive_cycle(1'b0, 4'b0010, 1'b0, 5'd0);
        check_value("drop_saturate", 32'(debugString[15:8]), 32'd255);
        drive_cycle(1'b0, 4'd0, 1'b1, 5'd0);
        idle(GUARD);

        // Long-running state 4: watchdog exit or indefinite hold
        drive_cycle(1'b0, 4'b1000, 1'b0, 5'd0);
        idle(TIMEOUT - 1);
        check_value("wd_last_active", 32'(currentState), 32'd4);
        idle(1);
`ifdef MUSICBOX_TIMEOUT_EN
        check_value("wd_exit_state", 32'(currentState), 32'd0);
        check_value("wd_exit_reason", 32'(debugString[6:5]), 32'd3);
`else
        check_value("no_wd_state", 32'(currentState), 32'd4);
`endif
        idle(1000 - TIMEOUT);
`ifndef MUSICBOX_TIMEOUT_EN
        check_value("no_wd_hold_1000", 32'(currentState), 32'd4);
`endif
        drive_cycle(1'b0, 4'd0, 1'b1, 5'd0);
        idle(GUARD + 1);

        // Reset mid-ACTIVE clears everything; no guard afterwards
        drive_cycle(1'b0, 4'b0001, 1'b0, 5'd0);
        drive_cycle(1'b1, 4'd0, 1'b0, 5'd0);
        check_value("rst_mid_state", 32'(currentState), 32'd0);
        check_value("rst_mid_busy", 32'(busy), 32'd0);
        check_value("rst_mid_debug", debugString, 32'd0);
        drive_cycle(1'b0, 4'b0010, 1'b0, 5'd0);
        check_value("post_rst_accept", 32'(currentState), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
